pipelined_control_unit: RTL

//  Control + hazard logic for the 5-stage (F/D/E/M/W) RV32I core; replaces the single-cycle master control.

---
 rtl/ctrl_pkg.sv | 105 ++++++++++
 rtl/hazard_unit.sv | 67 ++++++
 rtl/pipelined_control_unit.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the pipelined RV32I control unit: opcodes, ALU
// select codes, mux-select encodings and the D->E control bundle.
package ctrl_pkg;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] ITYPE  = 7'b0010011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  // ALU select codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;

  // Immediate format select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Write-back result select
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Next-PC select
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_ALU    = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRCA_RS1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;
  localparam logic [1:0] SRCA_ZERO = 2'b10;

  // Forwarding select
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Control bundle carried from D into E; all-zero is a bubble
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [3:0] alu_ctrl;
    logic [1:0] alu_src_a;
    logic       alu_src_b;
    logic [2:0] funct3;
    logic       illegal;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // ALU op for R/I arithmetic; SUB exists only in R-type, SRA in both
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic f7b5,
                                        input logic is_rtype);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Branch outcome from the flags of the E-stage SUB (c=1 means no borrow)
  function automatic logic branch_taken(input logic [2:0] f3, input logic z,
                                        input logic n, input logic v, input logic c);
    logic t;
    case (f3)
      3'b000:  t = z;
      3'b001:  t = ~z;
      3'b100:  t = n ^ v;
      3'b101:  t = ~(n ^ v);
      3'b110:  t = ~c;
      3'b111:  t = c;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/hazard_unit.sv
// Stall, flush and forwarding selects for the 5-stage pipeline.
// Build option FORWARDING_EN: with it, E operands are forwarded from M/W and
// only load-use stalls; without it, any RAW dependency on E or M stalls.
module hazard_unit
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic [REG_ADDR_W-1:0] rs1E,
  input  logic [REG_ADDR_W-1:0] rs2E,
  input  logic [REG_ADDR_W-1:0] rdE,
  input  logic [REG_ADDR_W-1:0] rdM,
  input  logic [REG_ADDR_W-1:0] rdW,
  input  logic                  regWriteE,
  input  logic                  regWriteM,
  input  logic                  regWriteW,
  input  logic                  memToRegE,
  input  logic [1:0]            pcSrcE,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  flushD,
  output logic                  flushE,
  output logic [1:0]            forwardAE,
  output logic [1:0]            forwardBE
);

  logic w_redirect;
  logic w_hazard;

  assign w_redirect = (pcSrcE != PC_PLUS4);

`ifdef FORWARDING_EN
  logic w_unused;
  assign w_unused = regWriteE;

  // Only a load in E can't be forwarded in time
  assign w_hazard = memToRegE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));

  // M result has priority over W since it is the younger write
  always_comb begin
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    if (regWriteM && (rdM != '0) && (rdM == rs1E))      forwardAE = FWD_M;
    else if (regWriteW && (rdW != '0) && (rdW == rs1E)) forwardAE = FWD_W;
    if (regWriteM && (rdM != '0) && (rdM == rs2E))      forwardBE = FWD_M;
    else if (regWriteW && (rdW != '0) && (rdW == rs2E)) forwardBE = FWD_W;
  end
`else
  logic w_unused;
  assign w_unused = ^{rs1E, rs2E, rdW, regWriteW, memToRegE};

  // Hold D until producers in E and M have reached W (RF writes before read)
  assign w_hazard = (regWriteE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D))) ||
                    (regWriteM && (rdM != '0) && ((rdM == rs1D) || (rdM == rs2D)));
  assign forwardAE = FWD_RF;
  assign forwardBE = FWD_RF;
`endif

  // A redirect makes the D instruction wrong-path, so it overrides any stall
  assign stallF = w_hazard && !w_redirect;
  assign stallD = w_hazard && !w_redirect;
  assign flushD = w_redirect;
  assign flushE = w_redirect || w_hazard;

endmodule

// File: rtl/pipelined_control_unit.sv
// Control + hazard logic for a 5-stage RV32I pipeline. Decodes in D, carries
// control through E/M/W registers, resolves branches/jumps in E.
// Build option FORWARDING_EN selects operand forwarding (see hazard_unit).
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 4   // codes are 4 bits wide; wider buses zero-extend
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcodeD,
  input  logic [2:0]            funct3D,
  input  logic                  funct7b5D,
  input  logic [REG_ADDR_W-1:0] rs1D,
  input  logic [REG_ADDR_W-1:0] rs2D,
  input  logic [REG_ADDR_W-1:0] rdD,
  input  logic                  zeroE,
  input  logic                  negE,
  input  logic                  ovfE,
  input  logic                  carryE,
  output logic [2:0]            immSrcD,
  output logic [ALU_CTRL_W-1:0] aluCtrlE,
  output logic [1:0]            aluSrcAE,
  output logic                  aluSrcBE,
  output logic [1:0]            pcSrcE,
  output logic                  memWriteM,
  output logic                  regWriteW,
  output logic [1:0]            resultSrcW,
  output logic [REG_ADDR_W-1:0] rdW,
  output logic                  stallF,
  output logic                  stallD,
  output logic                  flushD,
  output logic                  flushE,
  output logic [1:0]            forwardAE,
  output logic [1:0]            forwardBE,
  output logic                  illegalE
);

  ctrl_t                 w_ctrlD;
  logic [2:0]            w_immSrcD;
  ctrl_t                 r_ctrlE;
  logic [REG_ADDR_W-1:0] r_rs1E, r_rs2E, r_rdE;
  logic                  r_regWriteM, r_memWriteM;
  logic [1:0]            r_resultSrcM;
  logic [REG_ADDR_W-1:0] r_rdM;
  logic                  r_regWriteW;
  logic [1:0]            r_resultSrcW;
  logic [REG_ADDR_W-1:0] r_rdW;
  logic [1:0]            w_pcSrcE;
  logic                  w_flushE;

  // D-stage decode; unknown opcodes become a bubble flagged as illegal
  always_comb begin
    w_ctrlD   = '0;
    w_immSrcD = IMM_I;
    case (opcodeD)
      LOAD: begin
        w_ctrlD.reg_write  = 1'b1;
        w_ctrlD.result_src = RES_MEM;
        w_ctrlD.alu_src_b  = 1'b1;
      end
      STORE: begin
        w_ctrlD.mem_write = 1'b1;
        w_ctrlD.alu_src_b = 1'b1;
        w_immSrcD         = IMM_S;
      end
      RTYPE: begin
        w_ctrlD.reg_write = 1'b1;
        w_ctrlD.alu_ctrl  = alu_op(funct3D, funct7b5D, 1'b1);
      end
      ITYPE: begin
        w_ctrlD.reg_write = 1'b1;
        w_ctrlD.alu_src_b = 1'b1;
        w_ctrlD.alu_ctrl  = alu_op(funct3D, funct7b5D, 1'b0);
      end
      BRANCH: begin
        w_ctrlD.branch   = 1'b1;
        w_ctrlD.alu_ctrl = ALU_SUB;
        w_ctrlD.funct3   = funct3D;
        w_immSrcD        = IMM_B;
      end
      JAL: begin
        w_ctrlD.jump       = 1'b1;
        w_ctrlD.reg_write  = 1'b1;
        w_ctrlD.result_src = RES_PC4;
        w_immSrcD          = IMM_J;
      end
      JALR: begin
        w_ctrlD.jalr       = 1'b1;
        w_ctrlD.reg_write  = 1'b1;
        w_ctrlD.result_src = RES_PC4;
        w_ctrlD.alu_src_b  = 1'b1;
      end
      LUI: begin
        w_ctrlD.reg_write = 1'b1;
        w_ctrlD.alu_src_a = SRCA_ZERO;
        w_ctrlD.alu_src_b = 1'b1;
        w_immSrcD         = IMM_U;
      end
      AUIPC: begin
        w_ctrlD.reg_write = 1'b1;
        w_ctrlD.alu_src_a = SRCA_PC;
        w_ctrlD.alu_src_b = 1'b1;
        w_immSrcD         = IMM_U;
      end
      default: w_ctrlD.illegal = 1'b1;
    endcase
  end

  // D->E->M->W control registers; a flushed E loads a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrlE      <= '0;
      r_rs1E       <= '0;
      r_rs2E       <= '0;
      r_rdE        <= '0;
      r_regWriteM  <= 1'b0;
      r_memWriteM  <= 1'b0;
      r_resultSrcM <= RES_ALU;
      r_rdM        <= '0;
      r_regWriteW  <= 1'b0;
      r_resultSrcW <= RES_ALU;
      r_rdW        <= '0;
    end else begin
      if (w_flushE) begin
        r_ctrlE <= '0;
        r_rs1E  <= '0;
        r_rs2E  <= '0;
        r_rdE   <= '0;
      end else begin
        r_ctrlE <= w_ctrlD;
        r_rs1E  <= rs1D;
        r_rs2E  <= rs2D;
        r_rdE   <= rdD;
      end
      r_regWriteM  <= r_ctrlE.reg_write;
      r_memWriteM  <= r_ctrlE.mem_write;
      r_resultSrcM <= r_ctrlE.result_src;
      r_rdM        <= r_rdE;
      r_regWriteW  <= r_regWriteM;
      r_resultSrcW <= r_resultSrcM;
      r_rdW        <= r_rdM;
    end
  end

  // E-stage next-PC select: JALR uses the ALU sum, JAL/taken branch PC+imm
  always_comb begin
    w_pcSrcE = PC_PLUS4;
    if (r_ctrlE.jalr)
      w_pcSrcE = PC_ALU;
    else if (r_ctrlE.jump ||
             (r_ctrlE.branch && branch_taken(r_ctrlE.funct3, zeroE, negE, ovfE, carryE)))
      w_pcSrcE = PC_TARGET;
  end

  hazard_unit #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard (
    .rs1D     (rs1D),
    .rs2D     (rs2D),
    .rs1E     (r_rs1E),
    .rs2E     (r_rs2E),
    .rdE      (r_rdE),
    .rdM      (r_rdM),
    .rdW      (r_rdW),
    .regWriteE(r_ctrlE.reg_write),
    .regWriteM(r_regWriteM),
    .regWriteW(r_regWriteW),
    .memToRegE(r_ctrlE.result_src == RES_MEM),
    .pcSrcE   (w_pcSrcE),
    .stallF   (stallF),
    .stallD   (stallD),
    .flushD   (flushD),
    .flushE   (w_flushE),
    .forwardAE(forwardAE),
    .forwardBE(forwardBE)
  );

  // immSrcD is forced low during reset so every output reads 0 immediately
  assign immSrcD    = reset ? IMM_I : w_immSrcD;
  assign aluCtrlE   = ALU_CTRL_W'(r_ctrlE.alu_ctrl);
  assign aluSrcAE   = r_ctrlE.alu_src_a;
  assign aluSrcBE   = r_ctrlE.alu_src_b;
  assign pcSrcE     = w_pcSrcE;
  assign flushE     = w_flushE;
  assign memWriteM  = r_memWriteM;
  assign regWriteW  = r_regWriteW;
  assign resultSrcW = r_resultSrcW;
  assign rdW        = r_rdW;
  assign illegalE   = r_ctrlE.illegal;

endmodule
